// File: rtl/pc_sequencer.sv
// Program-flow controller for a 12-bit program counter register.
// Holds the PC while armed, launches on the falling edge of start, then picks
// the next PC each cycle (halt > stall > branch via LUT > increment) until halt.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | PC held via pc_start; start=1 arms and captures entry_pc
// LOAD  | one cycle: PC loads the entry register, run counter clears
// RUN   | program executing, next_pc chosen by halt/stall/branch/increment
// DONE  | halted: pc_done holds the PC, done raised until start=1
module pc_sequencer #(
    parameter int PC_W      = 12,
    parameter int LUT_DEPTH = 16,
    parameter int LUT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_W-1:0]      entry_pc,
    input  logic [PC_W-1:0]      cur_pc,
    input  logic                 halt_in,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [LUT_IDX_W-1:0] branch_idx,
    input  logic                 cfg_we,
    input  logic [LUT_IDX_W-1:0] cfg_idx,
    input  logic [PC_W-1:0]      cfg_data,
    output logic [PC_W-1:0]      next_pc,
    output logic                 pc_start,
    output logic                 pc_done,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [PC_W-1:0]   entry_q, entry_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];
    logic [PC_W-1:0]   lut_d [LUT_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   lut_rd;

    // Branch target lookup from stored contents; out-of-range indices read as 0.
    always_comb begin
        lut_rd = '0;
        if (32'(branch_idx) < LUT_DEPTH) begin
            lut_rd = lut_q[branch_idx];
        end
    end

    // PC-facing outputs decoded from the current state.
    always_comb begin
        next_pc  = entry_q;
        pc_start = 1'b0;
        pc_done  = 1'b0;
        unique case (state_q)
            IDLE: pc_start = 1'b1;
            LOAD: next_pc  = entry_q;
            RUN: begin
                if (halt_in || stall) begin
                    next_pc = cur_pc;
                end else if (branch_taken) begin
                    next_pc = lut_rd;
                end else begin
                    next_pc = cur_pc + PC_W'(1);
                end
            end
            DONE: begin
                pc_done = 1'b1;
                next_pc = cur_pc;
            end
            default: pc_start = 1'b1;
        endcase
    end

    // Next-state, arming, entry capture, run counter and LUT writes.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        lut_d   = lut_q;

        if (cfg_we && (32'(cfg_idx) < LUT_DEPTH)) begin
            lut_d[cfg_idx] = cfg_data;
        end

        // entry_pc is tracked every cycle start is high, whatever the state.
        if (start) begin
            entry_d = entry_pc;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (start) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (halt_in) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    armed_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            entry_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign done        = done_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the PC register around the DUT, issues
// directed stimulus, queues the expected outputs per cycle, and a monitor
// compares them at the falling clock edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] entry_pc;
    logic [11:0] cur_pc;
    logic        halt_in;
    logic        stall;
    logic        branch_taken;
    logic [3:0]  branch_idx;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [11:0] cfg_data;
    logic [11:0] next_pc;
    logic        pc_start;
    logic        pc_done;
    logic        done;
    logic [15:0] cycle_count;

    logic [11:0] pc_reg;

    typedef struct {
        string       nm;
        logic [11:0] npc;
        bit          cn;
        bit          ps;
        bit          pd;
        bit          dn;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .entry_pc     (entry_pc),
        .cur_pc       (cur_pc),
        .halt_in      (halt_in),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_idx   (branch_idx),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_data     (cfg_data),
        .next_pc      (next_pc),
        .pc_start     (pc_start),
        .pc_done      (pc_done),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The program counter register the sequencer steers.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_reg <= 12'h000;
        else if (!pc_start && !pc_done) pc_reg <= next_pc;
    end
    assign cur_pc = pc_reg;

    // Monitor: one queued expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if ((mon_e.cn && next_pc !== mon_e.npc) || pc_start !== mon_e.ps ||
                pc_done !== mon_e.pd || done !== mon_e.dn || cycle_count !== mon_e.cnt) begin
                bad++;
                $display("FAIL %s: got npc=%h pc_start=%b pc_done=%b done=%b cnt=%0d; want npc=%h(chk=%0b) pc_start=%b pc_done=%b done=%b cnt=%0d",
                         mon_e.nm, next_pc, pc_start, pc_done, done, cycle_count,
                         mon_e.npc, mon_e.cn, mon_e.ps, mon_e.pd, mon_e.dn, mon_e.cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [11:0] npc, input bit cn,
                       input bit ps, input bit pd, input bit dn, input logic [15:0] cnt);
        exp_t e;
        e.nm = nm; e.npc = npc; e.cn = cn; e.ps = ps; e.pd = pd; e.dn = dn; e.cnt = cnt;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; entry_pc = '0; halt_in = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_idx = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;

        // Reset and arm with entry 0x010, program lut[3]=0x2A0.
        cyc(); chk("reset", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); reset = 1'b0; chk("idle", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); start = 1'b1; entry_pc = 12'h010;
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_data = 12'h2A0;
        chk("idle_precap", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); cfg_we = 1'b0; chk("idle_armed", 12'h010, 1, 1, 0, 0, 16'd0);
        cyc(); start = 1'b0; chk("idle_fall", 12'h010, 1, 1, 0, 0, 16'd0);
        cyc(); chk("load", 12'h010, 1, 0, 0, 0, 16'd0);

        // Straight-line run 0x010..0x01F, halt at 0x020 on the 17th cycle.
        for (int k = 1; k <= 16; k++) begin
            cyc(); chk("run_inc", 12'(12'h010 + k), 1, 0, 0, 0, 16'(k - 1));
        end
        cyc(); halt_in = 1'b1; chk("run_halt", 12'h020, 1, 0, 0, 0, 16'd16);
        cyc(); halt_in = 1'b0; chk("done1", 12'h020, 1, 0, 1, 1, 16'd17);
        cyc(); chk("done_hold", 12'h020, 1, 0, 1, 1, 16'd17);
        cyc(); start = 1'b1; entry_pc = 12'hFFE; chk("done_start", 12'h020, 1, 0, 1, 1, 16'd17);
        cyc(); chk("done_to_idle", 12'hFFE, 1, 1, 0, 0, 16'd17);
        cyc(); start = 1'b0; chk("idle_fall2", 12'hFFE, 1, 1, 0, 0, 16'd17);
        cyc(); chk("load2", 12'hFFE, 1, 0, 0, 0, 16'd17);

        // Wrap from 0xFFF to 0x000, then abort mid-run with a new entry.
        cyc(); chk("run_ffe", 12'hFFF, 1, 0, 0, 0, 16'd0);
        cyc(); chk("run_wrap", 12'h000, 1, 0, 0, 0, 16'd1);
        cyc(); chk("run_000", 12'h001, 1, 0, 0, 0, 16'd2);
        cyc(); start = 1'b1; entry_pc = 12'h015; chk("run_abort", 12'h002, 1, 0, 0, 0, 16'd3);
        cyc(); chk("abort_idle", 12'h000, 0, 1, 0, 0, 16'd3);
        cyc(); start = 1'b0; chk("idle_fall3", 12'h015, 1, 1, 0, 0, 16'd3);
        cyc(); chk("load3", 12'h015, 1, 0, 0, 0, 16'd3);

        // Branch through lut[3] while rewriting it: old value is read this cycle.
        cyc(); branch_taken = 1'b1; branch_idx = 4'd3;
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_data = 12'h111;
        chk("branch_old", 12'h2A0, 1, 0, 0, 0, 16'd0);
        cyc(); cfg_we = 1'b0; stall = 1'b1; chk("stall_over_branch", 12'h2A0, 1, 0, 0, 0, 16'd1);
        cyc(); stall = 1'b0; chk("branch_new", 12'h111, 1, 0, 0, 0, 16'd2);
        cyc(); halt_in = 1'b1; stall = 1'b1; chk("halt_priority", 12'h111, 1, 0, 0, 0, 16'd3);
        cyc(); halt_in = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        chk("done2", 12'h111, 1, 0, 1, 1, 16'd4);

        // Relaunch from 0x030, then an async reset between edges.
        cyc(); start = 1'b1; entry_pc = 12'h030; chk("done2_start", 12'h111, 1, 0, 1, 1, 16'd4);
        cyc(); chk("idle4a", 12'h000, 0, 1, 0, 0, 16'd4);
        cyc(); chk("idle4b", 12'h030, 1, 1, 0, 0, 16'd4);
        cyc(); start = 1'b0; chk("idle_fall4", 12'h030, 1, 1, 0, 0, 16'd4);
        cyc(); chk("load4", 12'h030, 1, 0, 0, 0, 16'd4);
        cyc(); chk("run_030", 12'h031, 1, 0, 0, 0, 16'd0);
        cyc(); chk("run_031", 12'h032, 1, 0, 0, 0, 16'd1);
        cyc(); reset = 1'b1; chk("async_reset", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); reset = 1'b0; chk("post_reset", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); chk("no_launch1", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); chk("no_launch2", 12'h000, 1, 1, 0, 0, 16'd0);

        // LUT must be cleared by the reset: branch idx 3 now targets 0.
        cyc(); start = 1'b1; entry_pc = 12'h040; chk("idle5a", 12'h000, 1, 1, 0, 0, 16'd0);
        cyc(); chk("idle5b", 12'h040, 1, 1, 0, 0, 16'd0);
        cyc(); start = 1'b0; chk("idle_fall5", 12'h040, 1, 1, 0, 0, 16'd0);
        cyc(); chk("load5", 12'h040, 1, 0, 0, 0, 16'd0);
        cyc(); branch_taken = 1'b1; branch_idx = 4'd3; chk("lut_cleared", 12'h000, 1, 0, 0, 0, 16'd0);
        cyc(); branch_taken = 1'b0;

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
